weight_bit_serializer: RTL and testbench

Feeds the bit-serial SMAC datapath. Accepts one parallel weight word per MAC lane through a valid/ready handshake, then emits the weight bits LSB-first, one bit per lane per cycle. It drives the `w_and_s` shift strobe and the `cl_en` clear pulse consumed by the post-accumulator shift register. It also flags the MSB cycle so the accumulator can subtract the two's-complement sign term.

---
 rtl/weight_bit_serializer.sv | 108 ++++++++++
 tb/tb_weight_bit_serializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_bit_serializer.sv
// Parallel-to-serial weight feeder for the bit-serial SMAC datapath.
// Emits one bit per lane per cycle LSB-first, with clear/shift strobes and an MSB flag.
module weight_bit_serializer #(
  parameter int M  = 16,
  parameter int Pw = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [M*Pw-1:0] wgt_in,
  input  logic          wgt_valid,
  output logic          wgt_ready,
  input  logic          en,
  input  logic          abort,
  output logic [M-1:0]  w_bit,
  output logic          w_msb,
  output logic          w_and_s,
  output logic          cl_en,
  output logic          done
);

  localparam int CNT_W = $clog2(Pw);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Pw - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [M*Pw-1:0]   sr_q, sr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    wgt_ready = 1'b0;
    w_bit     = '0;
    w_msb     = 1'b0;
    w_and_s   = 1'b0;
    cl_en     = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        wgt_ready = 1'b1;
        // abort wins over a pending handshake
        if (!abort && wgt_valid) begin
          sr_d    = wgt_in;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        cl_en   = 1'b1;
        state_d = SHIFT;
      end

      SHIFT: begin
        for (int k = 0; k < M; k++) begin
          w_bit[k] = sr_q[k*Pw];
        end
        w_msb   = (cnt_q == CNT_LAST);
        w_and_s = en && !abort;
        if (en) begin
          for (int k = 0; k < M; k++) begin
            sr_d[k*Pw +: Pw] = {1'b0, sr_q[k*Pw+1 +: Pw-1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        done    = !abort;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end
  end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Scoreboard bench: stimulus queues the expected per-cycle output vector,
// a negedge monitor pops and compares it against the DUT.
module tb_weight_bit_serializer;

  localparam int M  = 16;
  localparam int Pw = 8;

  logic            clk;
  logic            rst_n;
  logic [M*Pw-1:0] wgt_in;
  logic            wgt_valid;
  logic            wgt_ready;
  logic            en;
  logic            abort;
  logic [M-1:0]    w_bit;
  logic            w_msb;
  logic            w_and_s;
  logic            cl_en;
  logic            done;

  weight_bit_serializer #(.M(M), .Pw(Pw)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wgt_in    (wgt_in),
    .wgt_valid (wgt_valid),
    .wgt_ready (wgt_ready),
    .en        (en),
    .abort     (abort),
    .w_bit     (w_bit),
    .w_msb     (w_msb),
    .w_and_s   (w_and_s),
    .cl_en     (cl_en),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         rdy;
    logic         cl;
    logic         ws;
    logic         msb;
    logic         dn;
    logic [M-1:0] bits;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  int    ws_seen = 0;
  int    ws_exp = 0;

  exp_t  mon_exp;
  exp_t  mon_got;
  string mon_name;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = '{rdy: wgt_ready, cl: cl_en, ws: w_and_s, msb: w_msb, dn: done, bits: w_bit};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s t=%0t got rdy/cl/ws/msb/dn/bits=%b/%b/%b/%b/%b/%h required %b/%b/%b/%b/%b/%h",
                 mon_name, $time, mon_got.rdy, mon_got.cl, mon_got.ws, mon_got.msb, mon_got.dn,
                 mon_got.bits, mon_exp.rdy, mon_exp.cl, mon_exp.ws, mon_exp.msb, mon_exp.dn,
                 mon_exp.bits);
      end
      if (w_and_s === 1'b1) ws_seen++;
    end
  end

  // Queue expectation for the current cycle, then advance one cycle.
  task automatic expect_cyc(input string nm, input logic rdy, input logic cl, input logic ws,
                            input logic msb, input logic dn, input logic [M-1:0] b);
    exp_t x;
    x = '{rdy: rdy, cl: cl, ws: ws, msb: msb, dn: dn, bits: b};
    exp_q.push_back(x);
    name_q.push_back(nm);
    if (ws) ws_exp++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M-1:0] bit_of(input logic [M*Pw-1:0] w, input int i);
    logic [M-1:0] b;
    for (int k = 0; k < M; k++) b[k] = w[k*Pw+i];
    return b;
  endfunction

  task automatic idle_cyc(input string nm);
    wgt_valid = 1'b0;
    expect_cyc(nm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // One group: optional stall of stall_n cycles at bit stall_bit,
  // optional abort or reset at a bit index (-1 = none).
  task automatic run_group(input logic [M*Pw-1:0] w, input int stall_bit, input int stall_n,
                           input int abort_bit, input int rst_bit, input logic hold_v);
    logic m;
    wgt_in    = w;
    wgt_valid = 1'b1;
    en        = 1'b1;
    abort     = 1'b0;
    expect_cyc("accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    wgt_valid = hold_v;
    expect_cyc("clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < Pw; i++) begin
      m = (i == Pw - 1);
      if (i == stall_bit) begin
        for (int s = 0; s < stall_n; s++) begin
          en = 1'b0;
          expect_cyc("stall", 1'b0, 1'b0, 1'b0, m, 1'b0, bit_of(w, i));
        end
      end
      en = 1'b1;
      if (i == abort_bit) begin
        abort = 1'b1;
        expect_cyc("abort_cyc", 1'b0, 1'b0, 1'b0, m, 1'b0, bit_of(w, i));
        abort = 1'b0;
        idle_cyc("post_abort");
        return;
      end
      if (i == rst_bit) begin
        rst_n = 1'b0;
        expect_cyc("rst_cyc", 1'b0, 1'b0, 1'b1, m, 1'b0, bit_of(w, i));
        rst_n = 1'b1;
        idle_cyc("post_rst");
        return;
      end
      expect_cyc("bit", 1'b0, 1'b0, 1'b1, m, 1'b0, bit_of(w, i));
    end
    expect_cyc("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  logic [M*Pw-1:0] w_a5, w_01, w_80, w_pat;

  initial begin
    rst_n     = 1'b0;
    wgt_in    = '0;
    wgt_valid = 1'b0;
    en        = 1'b0;
    abort     = 1'b0;

    w_a5 = '0;
    w_a5[7:0] = 8'hA5;
    for (int k = 0; k < M; k++) begin
      w_01[k*Pw +: Pw] = 8'h01;
      w_80[k*Pw +: Pw] = 8'h80;
      w_pat[k*Pw +: Pw] = 8'((k * 17) % 256);
    end

    @(posedge clk);
    #1;
    expect_cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    idle_cyc("reset_release");

    run_group(w_a5, -1, 0, -1, -1, 1'b0);
    idle_cyc("ready_again");

    run_group(w_a5, 2, 3, -1, -1, 1'b0);
    idle_cyc("ready_after_stall");

    run_group(w_01, -1, 0, -1, -1, 1'b1);
    run_group(w_80, -1, 0, -1, -1, 1'b0);
    idle_cyc("ready_after_b2b");

    run_group(w_a5, -1, 0, 4, -1, 1'b0);
    run_group(w_a5, -1, 0, -1, -1, 1'b0);
    idle_cyc("ready_after_recover");

    wgt_in    = w_a5;
    wgt_valid = 1'b1;
    abort     = 1'b1;
    expect_cyc("idle_abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    abort = 1'b0;
    idle_cyc("idle_abort_no_capture");

    run_group(w_a5, -1, 0, -1, 5, 1'b0);
    idle_cyc("idle_after_rst");

    run_group(w_pat, -1, 0, -1, -1, 1'b0);
    idle_cyc("ready_after_pattern");

    checks++;
    if (ws_seen != ws_exp) begin
      errors++;
      $display("FAIL strobe_count got=%0d required=%0d", ws_seen, ws_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
